// File: rtl/rom_read_seq.sv
// Read sequencer for the 32x16 bitline ROM macro: it accepts one word request,
// precharges with the wordline off, evaluates with it on, then returns the sampled bitlines.
module rom_read_seq #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int PRE_CYC  = 1,
  parameter int EVAL_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_bl,
  output logic              busy
);

  localparam int MAX_CYC = (PRE_CYC > EVAL_CYC) ? PRE_CYC : EVAL_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] PRE_LOAD  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    EVAL,
    RESP
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              en_nxt;
  logic              valid_nxt;
  logic [DATA_W-1:0] data_nxt;

  // Every ROM-facing pin is a flop so request inputs never reach the macro combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rom_addr  <= '0;
      rom_en    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rom_addr  <= addr_nxt;
      rom_en    <= en_nxt;
      rsp_valid <= valid_nxt;
      rsp_data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = rom_addr;
    en_nxt    = rom_en;
    valid_nxt = rsp_valid;
    data_nxt  = rsp_data;

    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_nxt  = req_addr;
          cnt_nxt   = PRE_LOAD;
          state_nxt = PRE;
        end
      end
      PRE: begin
        if (cnt == '0) begin
          cnt_nxt   = EVAL_LOAD;
          en_nxt    = 1'b1;
          state_nxt = EVAL;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      EVAL: begin
        // Bitlines are only trusted on the final evaluate edge.
        if (cnt == '0) begin
          data_nxt  = rom_bl;
          valid_nxt = 1'b1;
          en_nxt    = 1'b0;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        en_nxt    = 1'b0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/rom_read_seq.md
Name: rom_read_seq

Overview:
- Read sequencer that sits directly upstream of the 32x16 bitline ROM macro.
- Accepts word-read requests over a valid/ready handshake and drives the macro's ADDR and IN (wordline enable) pins through a precharge/evaluate sequence.
- Samples the BL bus at the end of evaluation and returns the word over a valid/ready response channel.
- Isolates the unclocked ROM from the synchronous fabric.

Parameters:
- ADDR_W, 5, ROM address width (32 words).
- DATA_W, 16, ROM bitline/data width.
- PRE_CYC, 1, cycles the address is held with wordline disabled (bitline precharge/settle); must be >= 1.
- EVAL_CYC, 2, cycles the wordline is enabled before BL is sampled; must be >= 1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  read request valid.
- req_addr  input  ADDR_W  requested word address.
- req_ready  output  1  sequencer can accept a request.
- rsp_valid  output  1  rsp_data holds a completed read.
- rsp_data  output  DATA_W  captured ROM word.
- rsp_ready  input  1  consumer accepts response.
- rom_addr  output  ADDR_W  drives ROM ADDR.
- rom_en  output  1  drives ROM IN (wordline enable).
- rom_bl  input  DATA_W  ROM BL bus, sampled only.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0, and immediately on assertion:
  - state=IDLE, counter=0.
  - rom_addr=0, rom_en=0, rsp_valid=0, rsp_data=0, busy=0, req_ready=1 after reset.
- FSM states: IDLE, PRE, EVAL, RESP. All outputs are registered or decoded from state; there is no combinational path from req_* to rom_*.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: latch req_addr into rom_addr, load counter=PRE_CYC-1, go to PRE.
- PRE:
  - rom_en=0; rom_addr held.
  - Decrement counter each cycle. When counter=0: load EVAL_CYC-1, go to EVAL.
- EVAL:
  - rom_en=1; rom_addr held.
  - Decrement counter each cycle. When counter=0, on that same edge:
    - rsp_data <= rom_bl.
    - rsp_valid <= 1.
    - rom_en <= 0 (rom_en is registered).
    - go to RESP.
- RESP:
  - rsp_valid=1; rsp_data stable; rom_en=0; rom_addr holds the last address.
  - On an edge with rsp_ready=1: rsp_valid <= 0, go to IDLE.
  - rsp_data retains its value after the handshake; it is not cleared.
- Latency: for a request accepted at edge T:
  - rom_en is high for exactly EVAL_CYC cycles, starting at edge T+PRE_CYC.
  - rsp_valid rises at edge T+PRE_CYC+EVAL_CYC (T+3 with defaults).
- Throughput: one read per PRE_CYC+EVAL_CYC+1 cycles minimum. req_ready=0 in PRE, EVAL and RESP; there is no overlap of requests.
- rsp_ready=1 on the first RESP cycle: RESP lasts exactly one cycle.
- req_valid and req_addr changes while busy are ignored; a held request is accepted on the first IDLE cycle.
- Address range: the full 0..2^ADDR_W-1 range is valid. There is no wrap or bounds logic; address 31 is a normal read.
- rom_bl is sampled only at the last EVAL edge; its value at all other times is don't-care.
- Reset mid-operation (any state): the in-flight read is dropped and all outputs return to reset values asynchronously. No response is produced for the dropped request.
- Counter width: clog2(max(PRE_CYC,EVAL_CYC))+1.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> rom_en=0, rsp_valid=0, rsp_data=16'h0000, rom_addr=0, req_ready=1 after release.
- Single read: ROM model returns 16'hA500|addr; request addr=5 accepted at edge T.
  - rom_addr=5 from T; rom_en=1 at T+1..T+2.
  - rsp_valid=1 at T+3 with rsp_data=16'hA505.
  - With rsp_ready=1, back to IDLE at T+4.
- Backpressure: read addr=31 with rsp_ready=0 for 5 cycles.
  - rsp_data=16'hA51F held stable; rsp_valid held 1; req_ready=0.
  - A pending req_valid (addr=2) is not accepted until one cycle after rsp_ready=1.
- Busy ignore: change req_addr 5->9 during PRE/EVAL -> rom_addr stays 5; response 16'hA505.
- Reset mid-EVAL: drop rst_n while rom_en=1 -> rom_en=0 and busy=0 immediately; no rsp_valid after release.
- Sweep: with PRE_CYC=2, EVAL_CYC=3, read addresses 0..31 back-to-back -> each rsp_data matches the model, each latency is 5 cycles, and rom_en pulses are exactly 3 cycles wide.
